// File: rtl/imm_gen_pipe_pkg.sv
// ---------------------------------------------------------------------------
// imm_pkg
//   Shared definitions for the immediate generator pipeline stage.
//   - imm_sel_t      : 3-bit immediate format select carried on in_sel
//   - IMM_* codes    : encodings of the select field
//   - sel_is_reserved: true for the select code that has no defined format
//
//   The stored entry {imm, tag, illegal} depends on the XLEN and TAG_W
//   parameters of the instantiating module, so it is declared there.
// ---------------------------------------------------------------------------
package imm_pkg;

    typedef logic [2:0] imm_sel_t;

    localparam imm_sel_t IMM_NONE  = 3'd0;  // no immediate, result is zero
    localparam imm_sel_t IMM_I     = 3'd1;  // loads, ALU-immediate, JALR
    localparam imm_sel_t IMM_S     = 3'd2;  // stores
    localparam imm_sel_t IMM_B     = 3'd3;  // conditional branches
    localparam imm_sel_t IMM_U     = 3'd4;  // LUI / AUIPC
    localparam imm_sel_t IMM_J     = 3'd5;  // JAL
    localparam imm_sel_t IMM_SHAMT = 3'd6;  // shift-by-immediate amount
    localparam imm_sel_t IMM_RSV   = 3'd7;  // reserved, flagged illegal

    function automatic logic sel_is_reserved(input imm_sel_t sel);
        return sel == IMM_RSV;
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe_if
//   Handshake bundle of the immediate generator stage.
//   Upstream side : flush, in_valid, in_ready, in_instr, in_sel, in_tag
//   Downstream    : out_valid, out_ready, out_imm, out_tag, out_illegal
//   Modports:
//     slave  - the immediate generator itself
//     master - the environment (decode front end and operand-mux consumer)
// ---------------------------------------------------------------------------
interface imm_gen_pipe_if
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) ();

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    imm_sel_t         in_sel;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    modport slave (
        input  flush,
        input  in_valid,
        output in_ready,
        input  in_instr,
        input  in_sel,
        input  in_tag,
        output out_valid,
        input  out_ready,
        output out_imm,
        output out_tag,
        output out_illegal
    );

    modport master (
        output flush,
        output in_valid,
        input  in_ready,
        output in_instr,
        output in_sel,
        output in_tag,
        input  out_valid,
        output out_ready,
        input  out_imm,
        input  out_tag,
        input  out_illegal
    );

endinterface

// File: rtl/imm_gen_pipe_decode.sv
// ---------------------------------------------------------------------------
// imm_decode
//   Purely combinational immediate extraction for RV32I/RV64I.
//   Ports:
//     instr   in  32    instruction word
//     sel     in  3     immediate format select (imm_pkg::IMM_*)
//     imm     out XLEN  sign-extended (or, for shifts, zero-extended) value
//     illegal out 1     select code is reserved
//   Parameter XLEN: 32 or 64.
// ---------------------------------------------------------------------------
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  imm_sel_t        sel,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    // Every format is first assembled as a 32-bit value whose bit 31 is the
    // correct sign for widening; shift amounts keep bit 31 clear so the same
    // sign extension zero-extends them.
    logic [31:0] raw;

    // The opcode field never contributes to any immediate.
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    always_comb begin
        // NOTE: defaults first so every path assigns raw/illegal; otherwise
        // the case below would infer latches.
        raw     = '0;
        illegal = 1'b0;
        case (sel)
            IMM_NONE:  raw = '0;
            IMM_I:     raw = {{20{instr[31]}}, instr[31:20]};
            IMM_S:     raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:     raw = {{20{instr[31]}}, instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            IMM_U:     raw = {instr[31:12], 12'b0};
            IMM_J:     raw = {{12{instr[31]}}, instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            // RV64 shifts use a 6-bit amount, RV32 a 5-bit one.
            IMM_SHAMT: raw = (XLEN == 64) ? {26'b0, instr[25:20]}
                                          : {27'b0, instr[24:20]};
            IMM_RSV:   illegal = sel_is_reserved(sel);
        endcase
    end

    // Widen to XLEN by replicating bit 31 (identity when XLEN is 32).
    assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
//   Registered immediate generator for the decode stage. One instruction
//   word per cycle enters, its immediate appears one cycle later. A main
//   entry drives the outputs and a single skid entry absorbs the word that
//   arrives in the same cycle downstream stalls, so in_ready can be a pure
//   register output with no combinational path from out_ready.
//   Ports:
//     clk    in  clock, rising edge
//     rst_n  in  asynchronous active-low reset, clears all entries
//     bus    slave modport of imm_gen_pipe_if (valid/ready on both sides,
//            synchronous flush, immediate/tag/illegal outputs)
//   Parameters: XLEN (32 or 64), TAG_W (sideband tag width).
// ---------------------------------------------------------------------------
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    imm_gen_pipe_if.slave bus
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } entry_t;

    entry_t dec_entry;
    entry_t main_q;
    entry_t skid_q;
    logic   main_valid;
    logic   skid_valid;

    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;

    logic accept;     // input transfer this cycle
    logic consume;    // output transfer this cycle
    logic main_free;  // main can load a new entry at this edge

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr   (bus.in_instr),
        .sel     (bus.in_sel),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    assign dec_entry = '{imm: dec_imm, tag: bus.in_tag, illegal: dec_illegal};

    // A held skid entry means both slots are occupied.
    assign bus.in_ready = !skid_valid;

    assign accept    = bus.in_valid && !skid_valid;
    assign consume   = main_valid && bus.out_ready;
    assign main_free = !main_valid || consume;

    // Main entry and all valid flags. Reset is asynchronous so out_valid
    // drops as soon as rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
        end else if (bus.flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                // The older skid word always goes first; no input can be
                // accepted this cycle because in_ready is low.
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= accept;
                if (accept) begin
                    main_q <= dec_entry;
                end
            end
        end else if (accept) begin
            // Main is stalled and occupied: park the word in the skid slot.
            skid_valid <= 1'b1;
        end
    end

    // Skid payload is only loaded when it becomes valid.
    always_ff @(posedge clk) begin
        // NOTE: skid payload has no reset; skid_valid qualifies it, so its
        // power-up contents are never observed.
        if (!bus.flush && !main_free && accept) begin
            skid_q <= dec_entry;
        end
    end

    // Outputs come straight from the main register, so they hold steady
    // while out_valid is high and out_ready is low.
    assign bus.out_valid   = main_valid;
    assign bus.out_imm     = main_q.imm;
    assign bus.out_tag     = main_q.tag;
    assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_gen_pipe
//   Drives an XLEN=32 and an XLEN=64 instance with identical stimulus and
//   compares both against a queue-based model of a two-deep FIFO whose
//   immediates are computed arithmetically from the instruction word.
// ---------------------------------------------------------------------------
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [2:0]  in_sel = '0;
    logic [31:0] in_tag = '0;
    logic        out_ready = 1'b0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) bus32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) bus64 ();

    assign bus32.flush     = flush;
    assign bus32.in_valid  = in_valid;
    assign bus32.in_instr  = in_instr;
    assign bus32.in_sel    = in_sel;
    assign bus32.in_tag    = in_tag;
    assign bus32.out_ready = out_ready;

    assign bus64.flush     = flush;
    assign bus64.in_valid  = in_valid;
    assign bus64.in_instr  = in_instr;
    assign bus64.in_sel    = in_sel;
    assign bus64.in_tag    = in_tag;
    assign bus64.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus32.slave)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus64.slave)
    );

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  sel;
        logic [31:0] tag;
    } txn_t;

    txn_t model_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic last_acc = 1'b0;

    // Immediate from the architectural definitions, via signed arithmetic.
    function automatic logic [63:0] ref_imm(input logic [31:0] w,
                                            input logic [2:0] sel,
                                            input int xlen);
        longint s;
        longint v;
        s = longint'($signed(w));
        case (sel)
            3'd1: v = s >>> 20;
            3'd2: v = ((s >>> 25) << 5) | longint'(w[11:7]);
            3'd3: v = ((s >>> 31) << 12) | (longint'(w[7]) << 11)
                      | (longint'(w[30:25]) << 5) | (longint'(w[11:8]) << 1);
            3'd4: v = (s >>> 12) << 12;
            3'd5: v = ((s >>> 31) << 20) | (longint'(w[19:12]) << 12)
                      | (longint'(w[20]) << 11) | (longint'(w[30:21]) << 1);
            3'd6: v = (xlen == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
            default: v = 0;
        endcase
        if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare both DUTs with the model, then advance one clock and apply
    // the same handshake to the model. Called at posedge+1.
    task automatic tick();
        txn_t h;
        logic acc;
        logic cons;
        chk("out_valid32", bus32.out_valid, model_q.size() > 0);
        chk("out_valid64", bus64.out_valid, model_q.size() > 0);
        chk("in_ready32", bus32.in_ready, model_q.size() < 2);
        chk("in_ready64", bus64.in_ready, model_q.size() < 2);
        if (model_q.size() > 0) begin
            h = model_q[0];
            chk("out_imm32", bus32.out_imm, ref_imm(h.instr, h.sel, 32));
            chk("out_imm64", bus64.out_imm, ref_imm(h.instr, h.sel, 64));
            chk("out_tag32", bus32.out_tag, h.tag);
            chk("out_tag64", bus64.out_tag, h.tag);
            chk("out_illegal32", bus32.out_illegal, h.sel == 3'd7);
            chk("out_illegal64", bus64.out_illegal, h.sel == 3'd7);
        end
        acc  = in_valid && (model_q.size() < 2) && !flush;
        cons = (model_q.size() > 0) && out_ready;
        @(posedge clk);
        #1;
        if (flush) begin
            model_q.delete();
        end else begin
            if (cons) void'(model_q.pop_front());
            if (acc) model_q.push_back('{instr: in_instr, sel: in_sel, tag: in_tag});
        end
        last_acc = acc;
    endtask

    // Present a word and hold it until accepted (bounded).
    task automatic send(input logic [31:0] w, input logic [2:0] sel,
                        input logic [31:0] tag);
        in_valid = 1'b1;
        in_instr = w;
        in_sel   = sel;
        in_tag   = tag;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_acc) break;
        end
        chk("send_accepted", last_acc, 1'b1);
        in_valid = 1'b0;
    endtask

    // Single word with out_ready high; result must be visible right after
    // the accepting edge.
    task automatic single(input logic [31:0] w, input logic [2:0] sel,
                          input logic [31:0] exp32, input logic exp_ill);
        send(w, sel, 32'hA5A5_0000 | 32'(sel));
        chk("single_valid", bus32.out_valid, 1'b1);
        chk("single_imm", bus32.out_imm, exp32);
        chk("single_illegal", bus32.out_illegal, exp_ill);
        tick();
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        chk("rst_out_valid", bus32.out_valid, 1'b0);
        chk("rst_out_imm", bus32.out_imm, 64'd0);
        chk("rst_out_tag", bus32.out_tag, 64'd0);
        chk("rst_out_illegal", bus32.out_illegal, 1'b0);
        chk("rst_in_ready", bus32.in_ready, 1'b1);
        chk("rst_out_imm64", bus64.out_imm, 64'd0);

        // Format vectors, one per cycle of latency
        out_ready = 1'b1;
        single(32'hFFF0_0093, 3'd1, 32'hFFFF_FFFF, 1'b0);
        chk("i_imm64", bus64.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        single(32'hFE20_AE23, 3'd2, 32'hFFFF_FFFC, 1'b0);
        single(32'hFE00_0CE3, 3'd3, 32'hFFFF_FFF8, 1'b0);
        single(32'h1234_50B7, 3'd4, 32'h1234_5000, 1'b0);
        single(32'hFFDF_F06F, 3'd5, 32'hFFFF_FFFC, 1'b0);
        single(32'h41F0_D093, 3'd6, 32'h0000_001F, 1'b0);
        single(32'h41F0_D093, 3'd7, 32'h0000_0000, 1'b1);
        single(32'h0000_0000, 3'd0, 32'h0000_0000, 1'b0);

        // instr[25] matters only for the 64-bit shift amount
        send(32'h03F0_1093, 3'd6, 32'h5A);
        chk("shamt64", bus64.out_imm, 64'd63);
        chk("shamt32", bus32.out_imm, 64'd31);
        tick();

        // Back-pressure: A to main, B to skid, C stalls
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'hFFF0_0093; in_sel = 3'd1; in_tag = 32'hA;
        tick();
        in_instr = 32'hFE20_AE23; in_sel = 3'd2; in_tag = 32'hB;
        tick();
        in_instr = 32'h1234_50B7; in_sel = 3'd4; in_tag = 32'hC;
        repeat (3) tick();
        chk("bp_in_ready_low", bus32.in_ready, 1'b0);
        chk("bp_head_tag", bus32.out_tag, 32'hA);
        out_ready = 1'b1;
        send(32'h1234_50B7, 3'd4, 32'hC);
        repeat (4) tick();
        chk("bp_drained", bus32.out_valid, 1'b0);

        // Flush with both entries full and a word offered
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'hFE00_0CE3; in_sel = 3'd3; in_tag = 32'h11;
        tick();
        in_tag = 32'h22;
        tick();
        flush = 1'b1; in_tag = 32'h33;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush_out_valid", bus32.out_valid, 1'b0);
        chk("flush_in_ready", bus32.in_ready, 1'b1);
        repeat (3) tick();

        // Asynchronous reset while holding a valid entry
        out_ready = 1'b0;
        send(32'hFFDF_F06F, 3'd5, 32'h44);
        chk("pre_rst_valid", bus32.out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid32", bus32.out_valid, 1'b0);
        chk("async_rst_imm32", bus32.out_imm, 64'd0);
        chk("async_rst_valid64", bus64.out_valid, 1'b0);
        chk("async_rst_imm64", bus64.out_imm, 64'd0);
        model_q.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'h1234_50B7, 3'd4, 32'h55);
        chk("post_rst_latency", bus32.out_valid, 1'b1);
        chk("post_rst_imm", bus32.out_imm, 32'h1234_5000);
        tick();

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = $urandom;
            in_sel    = 3'($urandom_range(0, 7));
            in_tag    = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (4) tick();
        chk("final_empty", bus32.out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
